knn_threshold_filter: RTL and testbench
=======================================

KNN_THRESHOLD_FILTER -- requirements
Module: knn_threshold_filter

Interface
REQ-001 The block SHALL have parameter LANES, 4, number of knn_entry_t lanes per beat (1..16).
REQ-002 The block SHALL have parameter B, 32, distance/mean width in bits; must match knn_entry_t.distance.
REQ-003 The block SHALL have parameter MEAN_SHIFT, 2, moving-average weight shift (1..B-1).
REQ-004 The block SHALL have parameter STALL_LIMIT, 3, count of consecutive zero-take beats before mean relaxation (>=1).
REQ-005 The block SHALL have parameter STRICT, 0; 1 = take on distance < mean, 0 = take on distance <= mean.
REQ-006 The block SHALL have one clock and a synchronous, active-low reset, with ports as follows: clock  in  1  sole clock, rising edge.
REQ-007 reset_n  in  1  synchronous active-low reset.
REQ-008 in_valid  in  1  input beat present.
REQ-009 in_ready  out  1  block accepts beat this cycle.
REQ-010 in_entries  in  LANES x knn_entry_t  candidate neighbours.
REQ-011 mean_load  in  1  load mean_init as running mean.
REQ-012 mean_init  in  B  value for mean_load.
REQ-013 flush  in  1  return to warm-up, drop pending output.
REQ-014 out_valid  out  1  output beat present.
REQ-015 out_ready  in  1  downstream accepts output.
REQ-016 out_entries  out  LANES x knn_entry_t  filtered entries.
REQ-017 out_take_mask  out  LANES  bit i = lane i taken.
REQ-018 out_any_taken  out  1  OR of out_take_mask.
REQ-019 mean_out  out  B  current running mean.
REQ-020 mean_valid  out  1  running mean is valid.

Function
REQ-021 The block SHALL accept a beat when in_valid && in_ready, with in_ready = !out_valid || out_ready; in_ready SHALL be 0 while reset_n is low.
REQ-022 Each accepted beat SHALL be registered to the output in the next cycle (latency 1); out_entries/out_take_mask SHALL hold stable while out_valid && !out_ready.
REQ-023 out_valid SHALL clear on out_ready when no new beat is accepted in the same cycle.
REQ-024 The FSM SHALL have two states: WARMUP (mean_valid=0) and RUN (mean_valid=1).
REQ-025 In WARMUP, lane take = entry.valid; on the first accepted beat with any valid lane, mean SHALL load the distance of the lowest-indexed valid lane and the state SHALL move to RUN.
REQ-026 In RUN, lane take = entry.valid && (distance <= mean, or < when STRICT=1), compared against the pre-update mean.
REQ-027 out_entries[i] SHALL copy distance, x, y, z and addr unchanged, with valid = take[i].
REQ-028 On an accepted RUN beat with any lane taken, with sel = distance of the lowest-indexed taken lane, mean SHALL update to mean - ((mean - sel) >> MEAN_SHIFT) (unsigned, no underflow since sel <= mean), and the stall counter SHALL clear.
REQ-029 On an accepted RUN beat with no lane taken, the stall counter SHALL increment; on reaching STALL_LIMIT, mean SHALL update to mean + (mean >> MEAN_SHIFT), saturating at 2^B-1, and the counter SHALL clear; a mean of 0 SHALL relax to 1.
REQ-030 Beats with all lanes invalid SHALL still be accepted and output, but SHALL NOT change mean or the stall counter.
REQ-031 mean_load SHALL set mean = mean_init, state to RUN, and stall counter to 0; a beat accepted in the same cycle SHALL be compared against mean_init, and its update is discarded.
REQ-032 flush SHALL set state to WARMUP, mean to 0, stall counter to 0, and out_valid to 0, and SHALL drop any beat in the same cycle; flush SHALL override mean_load.
REQ-033 mean_out SHALL be the registered mean.

Reset
REQ-034 While reset_n=0 at a rising edge, the block SHALL set out_valid=0, out_entries=0, out_take_mask=0, out_any_taken=0, mean_out=0, mean_valid=0, state=WARMUP and stall counter=0; reset overrides flush and mean_load.
REQ-035 In the first cycle after reset_n rises, the block SHALL drive in_ready=1.

Verification (LANES=4, B=32, MEAN_SHIFT=2, STALL_LIMIT=3, STRICT=0)
REQ-036 Warm-up: after reset, send beat distances {40,10,30,20}, all valid -> out_take_mask=4'b1111, mean_out=40, and mean_valid=1 in the next cycle.
REQ-037 Compare/update: with mean=40, send {50,8,41,60} -> mask=4'b0010, lane1 out valid=1 and others valid=0, and mean=32; then send {32,50,50,50} -> mask=4'b0001 and mean stays 32.
REQ-038 Stall relaxation: with mean=32, send 3 beats of all distances 100 -> masks 0 and mean=40 after the third beat; with mean=0xFFFF_FFF0, the relaxation SHALL saturate to 0xFFFF_FFFF.
REQ-039 Backpressure: hold out_ready=0 with out_valid=1 for 5 cycles while in_valid=1 -> in_ready=0, outputs stable, mean unchanged; releasing out_ready SHALL deliver each beat exactly once, in order.
REQ-040 Load/flush: mean_load with mean_init=16 together with beat {20,16,15,0} -> mask=4'b1110 and mean=16; flush together with mean_load -> WARMUP, mean_valid=0, out_valid=0.
REQ-041 Reset mid-operation: assert reset_n=0 while out_valid=1 and out_ready=0 -> all outputs at reset values next cycle, and the pending beat is lost.

Source files
------------

// File: rtl/knn_threshold_filter.sv
// Streaming k-NN candidate filter: passes lanes whose distance is within a
// self-adjusting running mean, with warm-up seeding and stall-driven relaxation.
package knn_pkg;
    typedef struct packed {
        logic        valid;
        logic [31:0] distance;
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] z;
        logic [15:0] addr;
    } knn_entry_t;
endpackage

module knn_threshold_filter
    import knn_pkg::*;
#(
    parameter int LANES       = 4,
    parameter int B           = 32,
    parameter int MEAN_SHIFT  = 2,
    parameter int STALL_LIMIT = 3,
    parameter bit STRICT      = 1'b0
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  knn_entry_t [LANES-1:0] in_entries,
    input  logic                   mean_load,
    input  logic [B-1:0]           mean_init,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output knn_entry_t [LANES-1:0] out_entries,
    output logic [LANES-1:0]       out_take_mask,
    output logic                   out_any_taken,
    output logic [B-1:0]           mean_out,
    output logic                   mean_valid
);

    localparam logic [0:0] ST_WARMUP = 1'b0;
    localparam logic [0:0] ST_RUN    = 1'b1;
    localparam int         SW        = $clog2(STALL_LIMIT + 1);

    logic [0:0]             state_q, state_d;
    logic [B-1:0]           mean_q, mean_d;
    logic [SW-1:0]          stall_q, stall_d;
    logic                   out_valid_q, out_valid_d;
    knn_entry_t [LANES-1:0] out_entries_q, out_entries_d;
    logic [LANES-1:0]       out_take_mask_q, out_take_mask_d;

    logic                   accept;
    logic                   cmp_run;
    logic [B-1:0]           cmp_mean;
    logic [B-1:0]           lane_dist [LANES];
    logic [LANES-1:0]       lane_valid;
    logic [LANES-1:0]       take;
    logic [B-1:0]           sel_dist;
    logic [B:0]             relax_sum;
    logic [B-1:0]           relaxed_mean;
    logic [B-1:0]           shrunk_mean;
    logic [SW-1:0]          stall_inc;

    assign in_ready = reset_n && (!out_valid_q || out_ready);
    // A beat arriving alongside flush is dropped, never registered.
    assign accept   = in_valid && in_ready && !flush;

    // A same-cycle mean_load supplies the threshold for the beat being compared.
    assign cmp_run  = mean_load || (state_q == ST_RUN);
    assign cmp_mean = mean_load ? mean_init : mean_q;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic below;
            assign lane_dist[gi]  = in_entries[gi].distance[B-1:0];
            assign lane_valid[gi] = in_entries[gi].valid;
            if (STRICT) begin : g_strict
                assign below = lane_dist[gi] < cmp_mean;
            end else begin : g_loose
                assign below = lane_dist[gi] <= cmp_mean;
            end
            assign take[gi] = lane_valid[gi] && (!cmp_run || below);
        end
    endgenerate

    // In warm-up take == valid, so this also yields the lowest valid lane.
    always_comb begin
        sel_dist = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (take[i]) begin
                sel_dist = lane_dist[i];
            end
        end
    end

    assign relax_sum    = {1'b0, mean_q} + {1'b0, (mean_q >> MEAN_SHIFT)};
    assign relaxed_mean = (mean_q == '0) ? B'(1) :
                          (relax_sum[B] ? {B{1'b1}} : relax_sum[B-1:0]);
    assign shrunk_mean  = mean_q - ((mean_q - sel_dist) >> MEAN_SHIFT);
    assign stall_inc    = stall_q + 1'b1;

    always_comb begin
        state_d         = state_q;
        mean_d          = mean_q;
        stall_d         = stall_q;
        out_valid_d     = out_valid_q;
        out_entries_d   = out_entries_q;
        out_take_mask_d = out_take_mask_q;

        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d     = 1'b1;
            out_take_mask_d = take;
            for (int i = 0; i < LANES; i++) begin
                out_entries_d[i]       = in_entries[i];
                out_entries_d[i].valid = take[i];
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        if (flush) begin
            state_d = ST_WARMUP;
            mean_d  = '0;
            stall_d = '0;
        end else if (mean_load) begin
            state_d = ST_RUN;
            mean_d  = mean_init;
            stall_d = '0;
        end else if (accept && (|lane_valid)) begin
            if (state_q == ST_WARMUP) begin
                state_d = ST_RUN;
                mean_d  = sel_dist;
            end else if (|take) begin
                mean_d  = shrunk_mean;
                stall_d = '0;
            end else if (stall_inc == SW'(STALL_LIMIT)) begin
                mean_d  = relaxed_mean;
                stall_d = '0;
            end else begin
                stall_d = stall_inc;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q         <= ST_WARMUP;
            mean_q          <= '0;
            stall_q         <= '0;
            out_valid_q     <= 1'b0;
            out_entries_q   <= '0;
            out_take_mask_q <= '0;
        end else begin
            state_q         <= state_d;
            mean_q          <= mean_d;
            stall_q         <= stall_d;
            out_valid_q     <= out_valid_d;
            out_entries_q   <= out_entries_d;
            out_take_mask_q <= out_take_mask_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_entries   = out_entries_q;
    assign out_take_mask = out_take_mask_q;
    assign out_any_taken = |out_take_mask_q;
    assign mean_out      = mean_q;
    assign mean_valid    = (state_q == ST_RUN);

endmodule

// File: tb/tb_knn_threshold_filter.sv
// Bench for knn_threshold_filter: directed scenarios plus randomized traffic
// compared against a transaction-level model of the filter rules.
module tb_knn_threshold_filter;
    import knn_pkg::*;

    localparam int LANES = 4;

    logic                   clock = 1'b0;
    logic                   reset_n;
    logic                   in_valid;
    logic                   in_ready;
    knn_entry_t [LANES-1:0] in_entries;
    logic                   mean_load;
    logic [31:0]            mean_init;
    logic                   flush;
    logic                   out_valid;
    logic                   out_ready;
    knn_entry_t [LANES-1:0] out_entries;
    logic [LANES-1:0]       out_take_mask;
    logic                   out_any_taken;
    logic [31:0]            mean_out;
    logic                   mean_valid;

    knn_threshold_filter #(
        .LANES(4), .B(32), .MEAN_SHIFT(2), .STALL_LIMIT(3), .STRICT(1'b0)
    ) dut (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_entries(in_entries), .mean_load(mean_load), .mean_init(mean_init),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_entries(out_entries), .out_take_mask(out_take_mask),
        .out_any_taken(out_any_taken), .mean_out(mean_out), .mean_valid(mean_valid)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: what the block should be showing after each edge.
    logic [31:0]            m_mean  = '0;
    bit                     m_run   = 1'b0;
    int                     m_stall = 0;
    bit                     m_ov    = 1'b0;
    knn_entry_t [LANES-1:0] m_ent   = '0;
    logic [LANES-1:0]       m_mask  = '0;

    task automatic check_val(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_beat(input logic [31:0] d0, input logic [31:0] d1,
                            input logic [31:0] d2, input logic [31:0] d3,
                            input logic [3:0] v);
        logic [31:0] d [4];
        d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
        for (int i = 0; i < LANES; i++) begin
            in_entries[i].valid    = v[i];
            in_entries[i].distance = d[i];
            in_entries[i].x        = 16'($urandom);
            in_entries[i].y        = 16'($urandom);
            in_entries[i].z        = 16'($urandom);
            in_entries[i].addr     = 16'($urandom);
        end
    endtask

    // Applies the filter rules to the inputs present at this edge.
    task automatic model_update();
        bit          acc, run, any_v, any_t;
        logic [31:0] thr, first_v, first_t;
        logic [3:0]  tk;
        longint      grown;
        if (!reset_n) begin
            m_mean = '0; m_run = 1'b0; m_stall = 0; m_ov = 1'b0; m_ent = '0; m_mask = '0;
            return;
        end
        acc   = in_valid && (!m_ov || out_ready) && !flush;
        thr   = mean_load ? mean_init : m_mean;
        run   = mean_load || m_run;
        any_v = 1'b0; any_t = 1'b0; first_v = '0; first_t = '0;
        for (int i = 0; i < LANES; i++) begin
            tk[i] = in_entries[i].valid && (!run || (in_entries[i].distance <= thr));
            if (in_entries[i].valid && !any_v) begin any_v = 1'b1; first_v = in_entries[i].distance; end
            if (tk[i] && !any_t) begin any_t = 1'b1; first_t = in_entries[i].distance; end
        end
        if (flush) m_ov = 1'b0;
        else if (acc) begin
            m_ov = 1'b1;
            m_mask = tk;
            m_ent = in_entries;
            for (int i = 0; i < LANES; i++) m_ent[i].valid = tk[i];
        end else if (out_ready) m_ov = 1'b0;

        if (flush) begin
            m_mean = '0; m_run = 1'b0; m_stall = 0;
        end else if (mean_load) begin
            m_mean = mean_init; m_run = 1'b1; m_stall = 0;
        end else if (acc && any_v) begin
            if (!m_run) begin
                m_mean = first_v; m_run = 1'b1;
            end else if (any_t) begin
                m_mean = m_mean - ((m_mean - first_t) / 4);
                m_stall = 0;
            end else begin
                m_stall++;
                if (m_stall == 3) begin
                    m_stall = 0;
                    grown = longint'(m_mean) + longint'(m_mean) / 4;
                    if (m_mean == 0) m_mean = 32'd1;
                    else if (grown > 64'hFFFF_FFFF) m_mean = 32'hFFFF_FFFF;
                    else m_mean = grown[31:0];
                end
            end
        end
    endtask

    // One clock: check in_ready, take the edge, then check registered outputs.
    task automatic step();
        bit handshake;
        #1;
        check_val("in_ready", 512'(in_ready), 512'(reset_n && (!m_ov || out_ready)));
        handshake = out_valid && out_ready;
        if (handshake && reset_n)
            $display("[TB] beat out mask=%b mean=%0h", out_take_mask, mean_out);
        @(posedge clock);
        model_update();
        #1;
        check_val("out_valid", 512'(out_valid), 512'(m_ov));
        check_val("mean_out", 512'(mean_out), 512'(m_mean));
        check_val("mean_valid", 512'(mean_valid), 512'(m_run));
        check_val("take_mask", 512'(out_take_mask), 512'(m_mask));
        check_val("any_taken", 512'(out_any_taken), 512'(|m_mask));
        check_val("entries", 512'(out_entries), 512'(m_ent));
        @(negedge clock);
    endtask

    knn_entry_t [LANES-1:0] held;

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; in_entries = '0; mean_load = 1'b0;
        mean_init = '0; flush = 1'b0; out_ready = 1'b1;
        @(negedge clock);
        step(); step();
        reset_n = 1'b1;
        check_val("rst_mean", 512'(mean_out), 512'(0));
        check_val("rst_mvalid", 512'(mean_valid), 512'(0));

        // Warm-up seeds mean from lane 0
        in_valid = 1'b1;
        set_beat(40, 10, 30, 20, 4'hF);
        step();
        check_val("warm_mask", 512'(out_take_mask), 512'(4'hF));
        check_val("warm_mean", 512'(mean_out), 512'(40));
        check_val("warm_mvalid", 512'(mean_valid), 512'(1));

        set_beat(50, 8, 41, 60, 4'hF);
        step();
        check_val("upd_mask", 512'(out_take_mask), 512'(4'b0010));
        check_val("upd_mean", 512'(mean_out), 512'(32));
        check_val("upd_l0_valid", 512'(out_entries[0].valid), 512'(0));
        check_val("upd_l1_valid", 512'(out_entries[1].valid), 512'(1));
        set_beat(32, 50, 50, 50, 4'hF);
        step();
        check_val("eq_mask", 512'(out_take_mask), 512'(4'b0001));
        check_val("eq_mean", 512'(mean_out), 512'(32));

        // Stall relaxation, then saturation near the top
        for (int k = 0; k < 3; k++) begin
            set_beat(100, 100, 100, 100, 4'hF);
            step();
            check_val("stall_mask", 512'(out_take_mask), 512'(0));
        end
        check_val("relax_mean", 512'(mean_out), 512'(40));
        in_valid = 1'b0; mean_load = 1'b1; mean_init = 32'hFFFF_FFF0;
        step();
        mean_load = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            set_beat(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'hF);
            step();
        end
        check_val("sat_mean", 512'(mean_out), 512'(32'hFFFF_FFFF));

        // Backpressure: one beat held, next beat waits
        in_valid = 1'b0; step();
        out_ready = 1'b0; in_valid = 1'b1;
        set_beat(1, 2, 3, 4, 4'hF);
        step();
        held = out_entries;
        set_beat(5, 6, 7, 8, 4'h5);
        for (int k = 0; k < 5; k++) begin
            step();
            check_val("bp_ready", 512'(in_ready), 512'(0));
            check_val("bp_hold", 512'(out_entries), 512'(held));
        end
        out_ready = 1'b1;
        step();
        check_val("bp_next_addr", 512'(out_entries[0].addr), 512'(in_entries[0].addr));
        in_valid = 1'b0; step();
        check_val("bp_drained", 512'(out_valid), 512'(0));

        // Load with a concurrent beat, then flush overriding load
        in_valid = 1'b1; mean_load = 1'b1; mean_init = 16;
        set_beat(20, 16, 15, 0, 4'hF);
        step();
        check_val("load_mask", 512'(out_take_mask), 512'(4'b1110));
        check_val("load_mean", 512'(mean_out), 512'(16));
        flush = 1'b1; mean_load = 1'b1; mean_init = 99;
        step();
        check_val("flush_mvalid", 512'(mean_valid), 512'(0));
        check_val("flush_ovalid", 512'(out_valid), 512'(0));
        flush = 1'b0; mean_load = 1'b0;

        // Reset while a beat is stuck at the output
        out_ready = 1'b0;
        set_beat(9, 9, 9, 9, 4'hF);
        step();
        reset_n = 1'b0;
        step();
        check_val("rst_mid_ovalid", 512'(out_valid), 512'(0));
        check_val("rst_mid_entries", 512'(out_entries), 512'(0));
        check_val("rst_mid_mean", 512'(mean_out), 512'(0));
        reset_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        step();

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            reset_n   = ($urandom_range(0, 199) != 0);
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            mean_load = ($urandom_range(0, 29) == 0);
            flush     = ($urandom_range(0, 49) == 0);
            mean_init = ($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, 200);
            for (int i = 0; i < LANES; i++) begin
                in_entries[i].valid    = ($urandom_range(0, 3) != 0);
                in_entries[i].distance = ($urandom_range(0, 9) == 0) ? $urandom : $urandom_range(0, 200);
                in_entries[i].x        = 16'($urandom);
                in_entries[i].y        = 16'($urandom);
                in_entries[i].z        = 16'($urandom);
                in_entries[i].addr     = 16'($urandom);
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
